// File: rtl/sargantana_icache_fill_arb_if.sv
// Signal bundle around the icache fill arbiter: demand and prefetch requests, the ifill
// request/response channel and the fill-write strobes. The arbiter uses the slave modport.
interface sargantana_icache_fill_arb_if #(
    parameter int PADDR_W = 40,
    parameter int WAY_W   = 2
);
    logic               flush_i;
    logic               dmd_valid_i;
    logic [PADDR_W-1:0] dmd_paddr_i;
    logic [WAY_W-1:0]   dmd_way_i;
    logic               dmd_kill_i;
    logic               dmd_ready_o;
    logic               dmd_done_o;
    logic               pf_valid_i;
    logic [PADDR_W-1:0] pf_paddr_i;
    logic [WAY_W-1:0]   pf_way_i;
    logic               pf_ready_o;
    logic               pf_drop_o;
    logic               l2_req_valid_o;
    logic [PADDR_W-1:0] l2_req_paddr_o;
    logic [WAY_W-1:0]   l2_req_way_o;
    logic               l2_req_ready_i;
    logic               l2_resp_valid_i;
    logic               l2_resp_inv_i;
    logic               fill_we_o;
    logic [WAY_W-1:0]   fill_way_o;
    logic               fill_is_pf_o;
    logic               busy_o;

    modport slave (
        input  flush_i, dmd_valid_i, dmd_paddr_i, dmd_way_i, dmd_kill_i,
               pf_valid_i, pf_paddr_i, pf_way_i, l2_req_ready_i, l2_resp_valid_i, l2_resp_inv_i,
        output dmd_ready_o, dmd_done_o, pf_ready_o, pf_drop_o, l2_req_valid_o, l2_req_paddr_o,
               l2_req_way_o, fill_we_o, fill_way_o, fill_is_pf_o, busy_o
    );

    modport master (
        output flush_i, dmd_valid_i, dmd_paddr_i, dmd_way_i, dmd_kill_i,
               pf_valid_i, pf_paddr_i, pf_way_i, l2_req_ready_i, l2_resp_valid_i, l2_resp_inv_i,
        input  dmd_ready_o, dmd_done_o, pf_ready_o, pf_drop_o, l2_req_valid_o, l2_req_paddr_o,
               l2_req_way_o, fill_we_o, fill_way_o, fill_is_pf_o, busy_o
    );
endinterface

// File: rtl/sargantana_icache_fill_arb.sv
// Single-outstanding icache fill arbiter between demand misses and a next-line prefetcher.
// Define ICACHE_NLP_FILL_EN to build the prefetch queue, de-duplication and demand merge.
module sargantana_icache_fill_arb #(
    parameter int PADDR_W    = 40,
    parameter int WAY_W      = 2,
    parameter int LINE_OFF_W = 5,
    parameter int PF_DEPTH   = 2
) (
    input logic clk_i,
    input logic rst_i,
    sargantana_icache_fill_arb_if.slave bus
);
    localparam int LINE_W = PADDR_W - LINE_OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
    typedef enum logic {OWN_DMD, OWN_PF} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q;
    logic              killed_q;
    logic              is_pf_q;
    logic [LINE_W-1:0] req_line_q;
    logic [WAY_W-1:0]  req_way_q;

    logic              busy, resp_ok, dmd_take, kill_now, killed_eff;
    logic              merge_ok, merge, pop_start;
    logic [LINE_W-1:0] dmd_line, pop_line;
    logic [WAY_W-1:0]  pop_way;
    logic              dmd_ready, l2_req_valid, fill_we, dmd_done;

    assign busy       = (state_q != S_IDLE);
    assign resp_ok    = bus.l2_resp_valid_i & ~bus.l2_resp_inv_i;
    assign dmd_line   = bus.dmd_paddr_i[PADDR_W-1:LINE_OFF_W];
    assign dmd_take   = (state_q == S_IDLE) & bus.dmd_valid_i & ~bus.dmd_kill_i;
    assign kill_now   = busy & (owner_q == OWN_DMD) & bus.dmd_kill_i;
    assign killed_eff = killed_q | kill_now;
    assign merge      = merge_ok & bus.dmd_valid_i;

    logic unused_dmd_off;
    assign unused_dmd_off = ^bus.dmd_paddr_i[LINE_OFF_W-1:0];

`ifdef ICACHE_NLP_FILL_EN
    localparam int PTR_W = $clog2(PF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LINE_W-1:0]   q_line [PF_DEPTH];
    logic [WAY_W-1:0]    q_way  [PF_DEPTH];
    logic [PF_DEPTH-1:0] q_vld;
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count;
    logic [LINE_W-1:0]   pf_line;
    logic                pf_ready, q_hit, dup, push, store, pop;

    assign pf_line   = bus.pf_paddr_i[PADDR_W-1:LINE_OFF_W];
    assign pf_ready  = (count != CNT_W'(PF_DEPTH));
    assign dup       = q_hit | (busy & (pf_line == req_line_q)) | (dmd_take & (pf_line == dmd_line));
    assign push      = bus.pf_valid_i & pf_ready & ~bus.flush_i;
    assign store     = push & ~dup;
    assign pop       = (state_q == S_IDLE) & ~dmd_take & (count != '0);
    // A head entry invalidated by an earlier demand is popped and discarded without a fill.
    assign pop_start = pop & q_vld[rd_ptr];
    assign pop_line  = q_line[rd_ptr];
    assign pop_way   = q_way[rd_ptr];
    assign merge_ok  = busy & (owner_q == OWN_PF) & (dmd_line == req_line_q) & ~bus.dmd_kill_i;

    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < PF_DEPTH; i++) begin
            if (q_vld[i] && (q_line[i] == pf_line)) q_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_vld  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            q_vld  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < PF_DEPTH; i++) begin
                if (dmd_take && (q_line[i] == dmd_line)) q_vld[i] <= 1'b0;
            end
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            if (store) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(store) - CNT_W'(pop);
        end
    end

    // NOTE: queue payload is not reset; q_vld alone decides whether an entry is live.
    always_ff @(posedge clk_i) begin
        if (store) begin
            q_line[wr_ptr] <= pf_line;
            q_way[wr_ptr]  <= bus.pf_way_i;
        end
    end

    logic unused_pf_off;
    assign unused_pf_off    = ^bus.pf_paddr_i[LINE_OFF_W-1:0];
    assign bus.pf_ready_o   = pf_ready;
    assign bus.pf_drop_o    = push & dup;
    assign bus.fill_is_pf_o = is_pf_q & busy;
`else
    assign pop_start = 1'b0;
    assign pop_line  = '0;
    assign pop_way   = '0;
    assign merge_ok  = 1'b0;

    logic unused_pf;
    assign unused_pf = ^{bus.flush_i, bus.pf_valid_i, bus.pf_paddr_i, bus.pf_way_i, is_pf_q};
    assign bus.pf_ready_o   = 1'b0;
    assign bus.pf_drop_o    = 1'b0;
    assign bus.fill_is_pf_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dmd_take || pop_start) state_d = S_REQ;
            S_REQ:   if (bus.l2_req_ready_i) state_d = S_WAIT;
            S_WAIT:  if (resp_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        dmd_ready    = 1'b0;
        l2_req_valid = 1'b0;
        fill_we      = 1'b0;
        dmd_done     = 1'b0;
        case (state_q)
            S_IDLE: dmd_ready = 1'b1;
            S_REQ: begin
                l2_req_valid = 1'b1;
                dmd_ready    = merge_ok;
            end
            S_WAIT: begin
                dmd_ready = merge_ok;
                if (resp_ok) begin
                    fill_we  = ~killed_eff;
                    dmd_done = ((owner_q == OWN_DMD) & ~killed_eff) | merge;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q    <= OWN_DMD;
            killed_q   <= 1'b0;
            is_pf_q    <= 1'b0;
            req_line_q <= '0;
            req_way_q  <= '0;
        end else if (dmd_take) begin
            owner_q    <= OWN_DMD;
            killed_q   <= 1'b0;
            is_pf_q    <= 1'b0;
            req_line_q <= dmd_line;
            req_way_q  <= bus.dmd_way_i;
        end else if (pop_start) begin
            owner_q    <= OWN_PF;
            killed_q   <= 1'b0;
            is_pf_q    <= 1'b1;
            req_line_q <= pop_line;
            req_way_q  <= pop_way;
        end else begin
            if (merge) begin
                owner_q  <= OWN_DMD;
                killed_q <= 1'b0;
            end else if (kill_now) begin
                killed_q <= 1'b1;
            end
            if ((state_q == S_WAIT) && resp_ok) killed_q <= 1'b0;
        end
    end

    assign bus.dmd_ready_o    = dmd_ready;
    assign bus.dmd_done_o     = dmd_done;
    assign bus.l2_req_valid_o = l2_req_valid;
    assign bus.l2_req_paddr_o = {req_line_q, {LINE_OFF_W{1'b0}}};
    assign bus.l2_req_way_o   = req_way_q;
    assign bus.fill_we_o      = fill_we;
    assign bus.fill_way_o     = req_way_q;
    assign bus.busy_o         = busy;
endmodule

// File: tb/tb_sargantana_icache_fill_arb.sv
// Scoreboard bench for the icache fill arbiter: directed demand/kill/prefetch/reset scenarios,
// with a negedge monitor that checks every l2 request and every valid fill response in order.
module tb_sargantana_icache_fill_arb;
    localparam int PADDR_W    = 40;
    localparam int WAY_W      = 2;
    localparam int LINE_OFF_W = 5;
    localparam int PF_DEPTH   = 2;
`ifdef ICACHE_NLP_FILL_EN
    localparam logic PF_ON = 1'b1;
`else
    localparam logic PF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [PADDR_W-1:0] paddr;
        logic [WAY_W-1:0]   way;
    } req_t;

    typedef struct packed {
        logic             we;
        logic [WAY_W-1:0] way;
        logic             done;
        logic             is_pf;
    } fill_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sargantana_icache_fill_arb_if #(.PADDR_W(PADDR_W), .WAY_W(WAY_W)) bus ();

    sargantana_icache_fill_arb #(
        .PADDR_W(PADDR_W), .WAY_W(WAY_W), .LINE_OFF_W(LINE_OFF_W), .PF_DEPTH(PF_DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    req_t  exp_req[$];
    fill_t exp_fill[$];
    req_t  mon_r;
    fill_t mon_f;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_req   = 0;
    int    n_drop  = 0;

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred where none was required", name);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic checkv(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_r(input logic [PADDR_W-1:0] paddr, input logic [WAY_W-1:0] way);
        exp_req.push_back('{paddr: paddr, way: way});
    endtask

    task automatic exp_f(input logic we, input logic [WAY_W-1:0] way, input logic done, input logic pf);
        exp_fill.push_back('{we: we, way: way, done: done, is_pf: pf});
    endtask

    task automatic idle_inputs();
        bus.flush_i         = 1'b0;
        bus.dmd_valid_i     = 1'b0;
        bus.dmd_paddr_i     = '0;
        bus.dmd_way_i       = '0;
        bus.dmd_kill_i      = 1'b0;
        bus.pf_valid_i      = 1'b0;
        bus.pf_paddr_i      = '0;
        bus.pf_way_i        = '0;
        bus.l2_req_ready_i  = 1'b0;
        bus.l2_resp_valid_i = 1'b0;
        bus.l2_resp_inv_i   = 1'b0;
    endtask

    task automatic demand(input logic [PADDR_W-1:0] paddr, input logic [WAY_W-1:0] way);
        bus.dmd_valid_i = 1'b1;
        bus.dmd_paddr_i = paddr;
        bus.dmd_way_i   = way;
    endtask

    task automatic prefetch(input logic [PADDR_W-1:0] paddr, input logic [WAY_W-1:0] way);
        bus.pf_valid_i = 1'b1;
        bus.pf_paddr_i = paddr;
        bus.pf_way_i   = way;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.l2_req_valid_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_now("l2_req_timeout");
    endtask

    // Accept the pending request for one cycle, then return a data response one cycle later.
    task automatic serve(input logic [WAY_W-1:0] way, input logic pf);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        bus.l2_req_ready_i = 1'b1;
        tick();
        bus.l2_req_ready_i = 1'b0;
        tick();
        exp_f(1'b1, way, ~pf, pf);
        bus.l2_resp_valid_i = 1'b1;
        tick();
        bus.l2_resp_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.l2_req_valid_o && bus.l2_req_ready_i) begin
                n_req++;
                if (exp_req.size() == 0) fail_now("l2_req_unexpected");
                else begin
                    mon_r = exp_req.pop_front();
                    checkv("l2_req_paddr", 64'(bus.l2_req_paddr_o), 64'(mon_r.paddr));
                    checkv("l2_req_way", 64'(bus.l2_req_way_o), 64'(mon_r.way));
                end
            end
            if (bus.l2_resp_valid_i && !bus.l2_resp_inv_i) begin
                if (exp_fill.size() == 0) fail_now("fill_unexpected_resp");
                else begin
                    mon_f = exp_fill.pop_front();
                    check1("fill_we", bus.fill_we_o, mon_f.we);
                    if (mon_f.we) checkv("fill_way", 64'(bus.fill_way_o), 64'(mon_f.way));
                    check1("dmd_done", bus.dmd_done_o, mon_f.done);
                    check1("fill_is_pf", bus.fill_is_pf_o, mon_f.is_pf);
                end
            end else if (bus.fill_we_o || bus.dmd_done_o) begin
                fail_now("fill_spurious");
            end
            if (bus.pf_drop_o) n_drop++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base_req;
        int base_drop;
        bit ok;

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_dmd_ready", bus.dmd_ready_o, 1'b1);
        check1("rst_l2_req_valid", bus.l2_req_valid_o, 1'b0);
        checkv("rst_l2_req_paddr", 64'(bus.l2_req_paddr_o), 64'd0);
        check1("rst_fill_we", bus.fill_we_o, 1'b0);
        check1("rst_dmd_done", bus.dmd_done_o, 1'b0);
        check1("rst_busy", bus.busy_o, 1'b0);
        check1("rst_pf_ready", bus.pf_ready_o, PF_ON);
        check1("rst_pf_drop", bus.pf_drop_o, 1'b0);
        check1("rst_fill_is_pf", bus.fill_is_pf_o, 1'b0);
        rst = 1'b0;
        tick();

        // Plain demand: ready late by one cycle, an invalidation in WAIT, then data.
        base_req = n_req;
        exp_r(40'h0080001220, 2'd2);
        exp_f(1'b1, 2'd2, 1'b1, 1'b0);
        demand(40'h0080001234, 2'd2);
        check1("t1_ready_idle", bus.dmd_ready_o, 1'b1);
        tick();
        bus.dmd_valid_i = 1'b0;
        check1("t1_req_valid_c1", bus.l2_req_valid_o, 1'b1);
        checkv("t1_req_paddr_c1", 64'(bus.l2_req_paddr_o), 64'h80001220);
        tick();
        check1("t1_req_valid_c2", bus.l2_req_valid_o, 1'b1);
        checkv("t1_req_paddr_c2", 64'(bus.l2_req_paddr_o), 64'h80001220);
        bus.l2_req_ready_i = 1'b1;
        tick();
        bus.l2_req_ready_i = 1'b0;
        check1("t1_req_released", bus.l2_req_valid_o, 1'b0);
        check1("t1_busy_wait", bus.busy_o, 1'b1);
        tick();
        bus.l2_resp_valid_i = 1'b1;
        bus.l2_resp_inv_i   = 1'b1;
        tick();
        bus.l2_resp_valid_i = 1'b0;
        bus.l2_resp_inv_i   = 1'b0;
        check1("t1_inv_ignored", bus.busy_o, 1'b1);
        repeat (2) tick();
        bus.l2_resp_valid_i = 1'b1;
        tick();
        bus.l2_resp_valid_i = 1'b0;
        check1("t1_done_one_cycle", bus.dmd_done_o, 1'b0);
        check1("t1_we_one_cycle", bus.fill_we_o, 1'b0);
        check1("t1_idle", bus.busy_o, 1'b0);
        checkv("t1_one_req", 64'(n_req - base_req), 64'd1);

        // Demand killed in WAIT is drained without a write.
        exp_r(40'h0000100040, 2'd1);
        exp_f(1'b0, 2'd0, 1'b0, 1'b0);
        demand(40'h0000100047, 2'd1);
        tick();
        bus.dmd_valid_i    = 1'b0;
        bus.l2_req_ready_i = 1'b1;
        tick();
        bus.l2_req_ready_i = 1'b0;
        bus.dmd_kill_i     = 1'b1;
        tick();
        bus.dmd_kill_i = 1'b0;
        tick();
        bus.l2_resp_valid_i = 1'b1;
        tick();
        bus.l2_resp_valid_i = 1'b0;
        check1("t2_ready_after_kill", bus.dmd_ready_o, 1'b1);
        check1("t2_idle", bus.busy_o, 1'b0);

`ifdef ICACHE_NLP_FILL_EN
        // Demand merged into an in-flight prefetch of the same line.
        base_req = n_req;
        exp_r(40'h1000, 2'd3);
        prefetch(40'h1000, 2'd3);
        check1("t3_pf_ready", bus.pf_ready_o, 1'b1);
        tick();
        bus.pf_valid_i = 1'b0;
        wait_req(ok);
        check1("t3_req_is_pf", bus.fill_is_pf_o, 1'b1);
        bus.l2_req_ready_i = 1'b1;
        tick();
        bus.l2_req_ready_i = 1'b0;
        exp_f(1'b1, 2'd3, 1'b1, 1'b1);
        demand(40'h1004, 2'd0);
        check1("t3_merge_ready", bus.dmd_ready_o, 1'b1);
        tick();
        bus.dmd_valid_i = 1'b0;
        check1("t3_ready_after_merge", bus.dmd_ready_o, 1'b0);
        tick();
        bus.l2_resp_valid_i = 1'b1;
        tick();
        bus.l2_resp_valid_i = 1'b0;
        checkv("t3_one_req", 64'(n_req - base_req), 64'd1);

        // Duplicate prefetch dropped, full queue stalls, FIFO issue order.
        base_req  = n_req;
        base_drop = n_drop;
        exp_r(40'h7000, 2'd0);
        exp_r(40'h2000, 2'd1);
        exp_r(40'h3000, 2'd1);
        exp_r(40'h4000, 2'd1);
        demand(40'h7000, 2'd0);
        tick();
        bus.dmd_valid_i    = 1'b0;
        bus.l2_req_ready_i = 1'b1;
        tick();
        bus.l2_req_ready_i = 1'b0;
        prefetch(40'h2000, 2'd1);
        check1("t4_first_kept", bus.pf_drop_o, 1'b0);
        tick();
        check1("t4_dup_dropped", bus.pf_drop_o, 1'b1);
        tick();
        prefetch(40'h3000, 2'd1);
        check1("t4_ready_3000", bus.pf_ready_o, 1'b1);
        check1("t4_3000_kept", bus.pf_drop_o, 1'b0);
        tick();
        prefetch(40'h4000, 2'd1);
        check1("t4_full_stall", bus.pf_ready_o, 1'b0);
        exp_f(1'b1, 2'd0, 1'b1, 1'b0);
        bus.l2_resp_valid_i = 1'b1;
        tick();
        bus.l2_resp_valid_i = 1'b0;
        check1("t4_full_in_idle", bus.pf_ready_o, 1'b0);
        tick();
        check1("t4_ready_after_pop", bus.pf_ready_o, 1'b1);
        tick();
        bus.pf_valid_i = 1'b0;
        repeat (3) serve(2'd1, 1'b1);
        repeat (3) tick();
        checkv("t4_drops", 64'(n_drop - base_drop), 64'd1);
        checkv("t4_reqs", 64'(n_req - base_req), 64'd4);

        // Demand for a queued line invalidates the queued copy.
        base_req = n_req;
        exp_r(40'h5000, 2'd2);
        prefetch(40'h5000, 2'd1);
        tick();
        bus.pf_valid_i = 1'b0;
        demand(40'h5000, 2'd2);
        check1("t5_dmd_ready", bus.dmd_ready_o, 1'b1);
        tick();
        bus.dmd_valid_i = 1'b0;
        check1("t5_req_is_dmd", bus.fill_is_pf_o, 1'b0);
        serve(2'd2, 1'b0);
        repeat (4) tick();
        check1("t5_idle", bus.busy_o, 1'b0);
        checkv("t5_one_req", 64'(n_req - base_req), 64'd1);

        // Flush empties the queue and beats a same-cycle push.
        base_req = n_req;
        exp_r(40'h9000, 2'd0);
        demand(40'h9000, 2'd0);
        tick();
        bus.dmd_valid_i    = 1'b0;
        bus.l2_req_ready_i = 1'b1;
        tick();
        bus.l2_req_ready_i = 1'b0;
        prefetch(40'h6000, 2'd1);
        tick();
        prefetch(40'h6100, 2'd1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i    = 1'b0;
        bus.pf_valid_i = 1'b0;
        exp_f(1'b1, 2'd0, 1'b1, 1'b0);
        bus.l2_resp_valid_i = 1'b1;
        tick();
        bus.l2_resp_valid_i = 1'b0;
        repeat (4) tick();
        check1("tf_idle", bus.busy_o, 1'b0);
        checkv("tf_one_req", 64'(n_req - base_req), 64'd1);
`else
        // Without the prefetch build, the prefetch port is inert.
        prefetch(40'h9000, 2'd1);
        for (int i = 0; i < 3; i++) begin
            check1("np_pf_ready", bus.pf_ready_o, 1'b0);
            check1("np_pf_drop", bus.pf_drop_o, 1'b0);
            tick();
        end
        bus.pf_valid_i = 1'b0;
        check1("np_idle", bus.busy_o, 1'b0);
`endif

        // Reset in WAIT; the late response must not write.
        exp_r(40'h8000, 2'd3);
        demand(40'h8000, 2'd3);
        tick();
        bus.dmd_valid_i    = 1'b0;
        bus.l2_req_ready_i = 1'b1;
        tick();
        bus.l2_req_ready_i = 1'b0;
        check1("t6_busy_before", bus.busy_o, 1'b1);
        rst = 1'b1;
        #1;
        check1("t6_rst_busy", bus.busy_o, 1'b0);
        check1("t6_rst_dmd_ready", bus.dmd_ready_o, 1'b1);
        check1("t6_rst_req_valid", bus.l2_req_valid_o, 1'b0);
        checkv("t6_rst_req_paddr", 64'(bus.l2_req_paddr_o), 64'd0);
        check1("t6_rst_pf_ready", bus.pf_ready_o, PF_ON);
        tick();
        rst = 1'b0;
        tick();
        exp_f(1'b0, 2'd0, 1'b0, 1'b0);
        bus.l2_resp_valid_i = 1'b1;
        tick();
        bus.l2_resp_valid_i = 1'b0;
        check1("t6_idle", bus.busy_o, 1'b0);

        checkv("sb_req_drained", 64'(exp_req.size()), 64'd0);
        checkv("sb_fill_drained", 64'(exp_fill.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sargantana_icache_fill_arb.md
Name: sargantana_icache_fill_arb

Overview:
Arbitrates the single iFill request path to the upper levels between two requesters: demand misses from the icache controller and a next-line prefetcher. At most one fill is outstanding. Queued prefetches are de-duplicated, and a demand that hits the in-flight prefetch line is merged into it. Killed demands are drained without writing the cache. Sits between the icache controller/replace unit and the ifill request/response interface.

Parameters:
PADDR_W, 40, physical address width
WAY_W, 2, way-select width (log2 of ICACHE_N_WAY)
LINE_OFF_W, 5, line offset bits; line compare uses paddr[PADDR_W-1:LINE_OFF_W]
PF_DEPTH, 2, prefetch queue entries (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  clears prefetch queue
dmd_valid_i  in  1  demand miss request
dmd_paddr_i  in  PADDR_W  demand line address
dmd_way_i  in  WAY_W  victim way for demand
dmd_kill_i  in  1  core kill of current demand
dmd_ready_o  out  1  demand accepted when valid&ready
dmd_done_o  out  1  1-cycle pulse: demand line filled
pf_valid_i  in  1  prefetch request
pf_paddr_i  in  PADDR_W  prefetch line address
pf_way_i  in  WAY_W  victim way for prefetch
pf_ready_o  out  1  prefetch queue not full
pf_drop_o  out  1  1-cycle pulse: prefetch discarded as duplicate
l2_req_valid_o  out  1  ifill request valid
l2_req_paddr_o  out  PADDR_W  line-aligned request address
l2_req_way_o  out  WAY_W  way to fill
l2_req_ready_i  in  1  upper level accepts request
l2_resp_valid_i  in  1  ifill response valid
l2_resp_inv_i  in  1  response is an invalidation, not data
fill_we_o  out  1  write fill data/tag into arrays
fill_way_o  out  WAY_W  way to write
fill_is_pf_o  out  1  current fill originated as prefetch
busy_o  out  1  fill outstanding (state != IDLE)

Behaviour:
- Clocking: one clock clk_i; reset rst_i is asynchronous and active-high.
- Reset: state IDLE, queue empty, killed=0, owner=DMD. All outputs 0 except dmd_ready_o=1, and pf_ready_o=1 when the prefetch feature is compiled in.
- Valid response: l2_resp_valid_i & ~l2_resp_inv_i. Invalidation responses never advance the FSM.
- FSM states:
  - IDLE: dmd_ready_o=1.
    - dmd_valid_i & ~dmd_kill_i: latch paddr (offset bits zeroed), way, owner=DMD; go to REQ.
    - Otherwise, if the queue is non-empty: pop the head, owner=PF; go to REQ.
    - Demand wins over prefetch in the same cycle. Accepting a demand invalidates any queued entry with the same line.
  - REQ: l2_req_valid_o=1; paddr and way held stable until l2_req_ready_i. On handshake, go to WAIT. A request is never withdrawn.
  - WAIT: on a valid response:
    - fill_we_o=1 and fill_way_o=latched way, unless killed.
    - dmd_done_o=1 if owner=DMD and ~killed.
    - Then go to IDLE and clear killed.
- Latency: demand accepted at cycle N -> l2_req_valid_o at N+1. Response at cycle M -> fill_we_o/dmd_done_o at M (combinational), IDLE at M+1.
- Kill: dmd_kill_i while owner=DMD in REQ or WAIT sets killed. The request still issues, and the response is consumed with fill_we_o=0. Kill while owner=PF has no effect.
- Merge: in REQ/WAIT with owner=PF, a dmd_valid_i whose line matches the in-flight line is accepted (dmd_ready_o=1). That sets owner=DMD, clears killed, and keeps fill_is_pf_o=1. Any other demand sees dmd_ready_o=0 until IDLE.
- Prefetch queue (FIFO):
  - Push on pf_valid_i & pf_ready_o.
  - pf_ready_o = ~full, registered occupancy, no bypass.
  - If the pushed line matches a valid queue entry, the in-flight line, or the demand line accepted that cycle, it is not stored and pf_drop_o pulses.
  - Simultaneous push and pop when full: push refused (pf_ready_o=0). Pointers wrap modulo PF_DEPTH.
- flush_i: empties the queue next cycle and has priority over a same-cycle push. The in-flight fill is not aborted.
- Response in IDLE (e.g., after reset mid-operation): ignored, no outputs.

Optional Feature:
ICACHE_NLP_FILL_EN.
- Defined: prefetch port, queue, merge, and dedup are active as described.
- Undefined: queue and merge logic are removed; pf_ready_o=0, pf_drop_o=0, fill_is_pf_o=0, and pf_* inputs are ignored. Demand behaviour is unchanged.

Test Plan:
- Demand 0x80001234, way 2; l2_req_ready_i on 2nd cycle; response 5 cycles later -> l2_req_paddr_o=0x80001220 held 2 cycles; fill_we_o=1, fill_way_o=2, dmd_done_o=1 for one cycle.
- Demand, then dmd_kill_i during WAIT -> fill_we_o=0, dmd_done_o=0 on response; dmd_ready_o=1 the next cycle.
- Prefetch 0x1000 in flight; demand 0x1004 in WAIT -> accepted immediately; response gives fill_we_o=1, fill_is_pf_o=1, dmd_done_o=1, and only one l2 request is issued.
- Push prefetches 0x2000, 0x2000, 0x3000, 0x4000 while busy -> second is dropped (pf_drop_o); 0x4000 is stalled by pf_ready_o=0. Issue order: 0x2000, 0x3000.
- IDLE with queue holding 0x5000; same-cycle demand 0x5000 -> demand issued, queued entry invalidated, only one request issued.
- rst_i asserted in WAIT, then a late response -> all outputs return to reset values; the response produces no fill_we_o.
